layer_scanner: RTL

Parametrised successor to the single-layer activator in the LED cube driver. Drives the one-hot layer enable lines with a programmable hold time. Inserts a blanking gap before each layer and requests column data for it. Runs either one layer per start (single-shot) or a continuous sweep of all layers with per-layer and per-frame completion pulses.

---
 rtl/led_cube_pkg.sv | 16 +
 rtl/layer_scanner_if.sv | 43 ++++
 rtl/layer_timer.sv | 32 +++
 rtl/layer_scanner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/led_cube_pkg.sv
// Shared definitions for the LED cube layer scanner.
// Contents: scan_state_e (scanner FSM states) and the default build
// constants for the layer count, layer hold time and blanking gap.
package led_cube_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } scan_state_e;

  localparam int DEF_NUM_LAYERS   = 8;
  localparam int DEF_HOLD_CYCLES  = 750000;
  localparam int DEF_BLANK_CYCLES = 16;

endpackage

// File: rtl/layer_scanner_if.sv
// Control/status bundle between a scan controller and layer_scanner.
// Optional macro LAYER_PWM_EN adds the 8-bit duty input.
// master: drives start, scan_mode, stop, layer_i (and duty);
//         observes ready, layer_idx, load_req, layer_out, done, frame_done.
// slave : the reverse (layer_scanner side).
interface layer_scanner_if
  import led_cube_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS
);
  localparam int LW = $clog2(NUM_LAYERS);

  logic                  start;
  logic                  scan_mode;
  logic                  stop;
  logic [LW-1:0]         layer_i;
`ifdef LAYER_PWM_EN
  logic [7:0]            duty;
`endif
  logic                  ready;
  logic [LW-1:0]         layer_idx;
  logic                  load_req;
  logic [NUM_LAYERS-1:0] layer_out;
  logic                  done;
  logic                  frame_done;

  modport master (
`ifdef LAYER_PWM_EN
    output duty,
`endif
    output start, scan_mode, stop, layer_i,
    input  ready, layer_idx, load_req, layer_out, done, frame_done
  );

  modport slave (
`ifdef LAYER_PWM_EN
    input  duty,
`endif
    input  start, scan_mode, stop, layer_i,
    output ready, layer_idx, load_req, layer_out, done, frame_done
  );

endinterface

// File: rtl/layer_timer.sv
// Loadable down-counter timing the BLANK and ACTIVE phases.
// Ports: clk, rst (sync, active-high), load (reload with load_val),
//        load_val (count start value), tc (high while the count is zero).
// The count stops at zero instead of wrapping.
module layer_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] cnt_r;

  // Count register: reload on load, otherwise decrement down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/layer_scanner.sv
// One-hot LED cube layer driver with a blanking gap before every layer.
// Ports: clk, rst (sync, active-high), bus (layer_scanner_if.slave):
//   start/scan_mode/layer_i launch a single layer or a continuous sweep,
//   stop ends a sweep after the current layer, ready is high in IDLE,
//   load_req asks the column driver for layer_idx data, layer_out is the
//   one-hot enable, done/frame_done pulse after each layer / each frame.
// Optional macro LAYER_PWM_EN: duty gates layer_out inside ACTIVE.
// All outputs come straight from registers loaded with next-state values,
// so they line up with the state they describe.
module layer_scanner
  import led_cube_pkg::*;
#(
  parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input logic           clk,
  input logic           rst,
  layer_scanner_if.slave bus
);

  localparam int LW   = $clog2(NUM_LAYERS);
  localparam int MAXC = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  scan_state_e           state_r, state_s;
  logic [LW-1:0]         idx_r, idx_s;
  logic                  mode_r, mode_s;
  logic                  stop_pend_r, stop_pend_s;
  logic                  ready_r, load_req_r, load_req_s;
  logic                  done_r, done_s, frame_done_r, frame_done_s;
  logic [NUM_LAYERS-1:0] layer_out_r, layer_out_s;
  logic                  tmr_load_s, tmr_tc_s;
  logic [CW-1:0]         tmr_val_s;
  logic                  stop_now_s;
`ifdef LAYER_PWM_EN
  logic [7:0]            pwm_r, pwm_s, duty_r, duty_s;
`endif

  layer_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tmr_tc_s)
  );

  // Next-state logic: phase sequencing, layer advance, stop handling, pulses.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    mode_s       = mode_r;
    stop_pend_s  = stop_pend_r;
    load_req_s   = 1'b0;
    done_s       = 1'b0;
    frame_done_s = 1'b0;
    tmr_load_s   = 1'b0;
    tmr_val_s    = {CW{1'b0}};
    // A stop seen on the final ACTIVE cycle still ends the sweep there.
    stop_now_s   = stop_pend_r | (bus.stop & mode_r);
    case (state_r)
      IDLE: begin
        if (bus.start && ({1'b0, bus.layer_i} < (LW+1)'(NUM_LAYERS))) begin
          state_s    = BLANK;
          idx_s      = bus.layer_i;
          mode_s     = bus.scan_mode;
          load_req_s = 1'b1;
          tmr_load_s = 1'b1;
          tmr_val_s  = CW'(BLANK_CYCLES - 1);
        end else begin
          state_s = IDLE;
        end
      end
      BLANK: begin
        stop_pend_s = stop_now_s;
        if (tmr_tc_s) begin
          state_s    = ACTIVE;
          tmr_load_s = 1'b1;
          tmr_val_s  = CW'(HOLD_CYCLES - 1);
        end else begin
          state_s = BLANK;
        end
      end
      ACTIVE: begin
        stop_pend_s = stop_now_s;
        if (tmr_tc_s) begin
          done_s       = 1'b1;
          frame_done_s = mode_r && (idx_r == LW'(NUM_LAYERS - 1));
          tmr_load_s   = 1'b1;
          if (!mode_r || stop_now_s) begin
            state_s     = IDLE;
            stop_pend_s = 1'b0;
            tmr_val_s   = {CW{1'b0}};
          end else begin
            state_s    = BLANK;
            idx_s      = (idx_r == LW'(NUM_LAYERS - 1)) ? {LW{1'b0}}
                                                        : idx_r + {{(LW-1){1'b0}}, 1'b1};
            load_req_s = 1'b1;
            tmr_val_s  = CW'(BLANK_CYCLES - 1);
          end
        end else begin
          state_s = ACTIVE;
        end
      end
      default: begin
        state_s     = IDLE;
        stop_pend_s = 1'b0;
      end
    endcase
  end

`ifdef LAYER_PWM_EN
  // PWM phase: clear and capture duty on ACTIVE entry, count during ACTIVE.
  always_comb begin
    pwm_s  = pwm_r;
    duty_s = duty_r;
    if ((state_s == ACTIVE) && (state_r != ACTIVE)) begin
      pwm_s  = 8'd0;
      duty_s = bus.duty;
    end else if (state_r == ACTIVE) begin
      pwm_s = pwm_r + 8'd1;
    end else begin
      pwm_s = pwm_r;
    end
  end
`endif

  // Layer enable for the coming cycle: one-hot only while ACTIVE.
  always_comb begin
    layer_out_s = {NUM_LAYERS{1'b0}};
`ifdef LAYER_PWM_EN
    if ((state_s == ACTIVE) && (pwm_s < duty_s)) begin
`else
    if (state_s == ACTIVE) begin
`endif
      layer_out_s = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << idx_s;
    end else begin
      layer_out_s = {NUM_LAYERS{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= {LW{1'b0}};
      mode_r       <= 1'b0;
      stop_pend_r  <= 1'b0;
      ready_r      <= 1'b1;
      load_req_r   <= 1'b0;
      done_r       <= 1'b0;
      frame_done_r <= 1'b0;
      layer_out_r  <= {NUM_LAYERS{1'b0}};
`ifdef LAYER_PWM_EN
      pwm_r        <= 8'd0;
      duty_r       <= 8'd0;
`endif
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      mode_r       <= mode_s;
      stop_pend_r  <= stop_pend_s;
      ready_r      <= (state_s == IDLE);
      load_req_r   <= load_req_s;
      done_r       <= done_s;
      frame_done_r <= frame_done_s;
      layer_out_r  <= layer_out_s;
`ifdef LAYER_PWM_EN
      pwm_r        <= pwm_s;
      duty_r       <= duty_s;
`endif
    end
  end

  assign bus.ready      = ready_r;
  assign bus.layer_idx  = idx_r;
  assign bus.load_req   = load_req_r;
  assign bus.done       = done_r;
  assign bus.frame_done = frame_done_r;
  assign bus.layer_out  = layer_out_r;

endmodule
